wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the ALU writeback stream (EXE/WB pipeline register outputs) and a multi-cycle MDU (mul/div) result stream.
- ALU has fixed priority. MDU results wait in a DEPTH-entry FIFO.
- A starvation counter forces a one-cycle pipeline stall so buffered MDU results always drain.
- Sits between the EXE/WB register, the MDU and the register file write port.

Parameters:
DSIZE, 16, data width of write data
ASIZE, 5, register address width
DEPTH, 2, MDU result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive denied cycles before a forced stall (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle (R/I-type writeback)
alu_waddr  in  ASIZE  ALU destination register
alu_wdata  in  DSIZE  ALU result
mdu_valid  in  1  MDU result offered
mdu_waddr  in  ASIZE  MDU destination register
mdu_wdata  in  DSIZE  MDU result
mdu_ready  out  1  MDU result accepted when mdu_valid&&mdu_ready
rf_wen  out  1  register file write enable (registered)
rf_waddr  out  ASIZE  register file write address (registered)
rf_wdata  out  DSIZE  register file write data (registered)
pipe_stall  out  1  freeze upstream pipeline for this cycle (registered)
err_alu_in_stall  out  1  sticky: alu_valid seen while pipe_stall=1

Behaviour:
- Reset: clk and rst as already decided (synchronous, active-high). Reset clears rf_wen, rf_waddr, rf_wdata, pipe_stall, err_alu_in_stall, FIFO count/pointers/entry-valid bits and the starve counter to 0. Reset mid-operation discards all buffered MDU results.
- mdu_ready = (count < DEPTH). It is a function of registered state only. No accept-when-full-while-popping.
- Grant, evaluated every cycle; the winner appears on rf_* at the next posedge (latency 1):
  1. alu_valid=1 -> ALU.
  2. Else FIFO non-empty -> FIFO head is popped. A live head sets rf_wen=1. A dead head sets rf_wen=0 (slot consumed, no write).
  3. Else mdu_valid&&mdu_ready -> MDU input bypasses the FIFO straight to rf_* and is not pushed.
  4. Else rf_wen=0. rf_waddr and rf_wdata hold their previous values.
- Push: an accepted MDU result that is not bypassed is written at the tail. Push and pop in the same cycle are legal; count is unchanged.
- Ordering kill rule: when alu_valid=1, every FIFO entry whose waddr equals alu_waddr has its live bit cleared, because the ALU value is newer.
  - An MDU input accepted in the same cycle with mdu_waddr==alu_waddr is treated as older. It is handshaken and dropped: not pushed, not written.
- Starvation:
  - starve_cnt increments each cycle the FIFO head is live and alu_valid=1.
  - It clears on any head pop or when the FIFO is empty.
  - When starve_cnt reaches STARVE_LIMIT, pipe_stall=1 on the next cycle for exactly one cycle, and starve_cnt clears.
- Stall cycle (pipe_stall=1): upstream must drive alu_valid=0, and the FIFO head is granted.
  - If alu_valid=1 anyway, the ALU still wins, the kill rule applies and err_alu_in_stall sets (cleared only by rst).
- Pointers wrap modulo DEPTH. Count is ASIZE-independent, width clog2(DEPTH)+1.
- No address-0 special case; register-file policy handles r0.

Test Plan:
- Reset then idle: rst=1 two cycles -> rf_wen=0, pipe_stall=0, mdu_ready=1, err=0; hold for 3 idle cycles, all outputs stay 0.
- ALU only: alu_valid=1, waddr=3, wdata=0x1234 -> next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x1234; alu_valid=0 -> rf_wen=0.
- Bypass vs buffer: MDU waddr=7 data=0xBEEF with ALU idle and FIFO empty -> rf_* shows 7/0xBEEF next cycle, count stays 0. Repeat with alu_valid=1 waddr=2 -> ALU written first, MDU written the following cycle.
- Full FIFO: with DEPTH=2, push 2 MDU results while alu_valid=1 continuously -> mdu_ready=0. Third mdu_valid is not accepted until the first pop.
- Starvation: FIFO holds a live entry (addr 5, 0x00AA) and alu_valid=1 to other addresses for 4 cycles -> pipe_stall=1 on the 5th cycle. Bench drops alu_valid -> rf writes 5/0x00AA, pipe_stall returns to 0 the next cycle.
- Kill and same-cycle drop: FIFO entry addr 9, then alu_valid waddr=9 -> entry pops later with rf_wen=0. MDU addr 4 offered in the same cycle as ALU addr 4 -> mdu_ready=1, only the ALU value is written. alu_valid during pipe_stall -> err_alu_in_stall=1 until rst.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between ALU writeback and buffered MDU results
module wb_port_arbiter #(
    parameter int DSIZE        = 16,
    parameter int ASIZE        = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [ASIZE-1:0] alu_waddr,
    input  logic [DSIZE-1:0] alu_wdata,
    input  logic             mdu_valid,
    input  logic [ASIZE-1:0] mdu_waddr,
    input  logic [DSIZE-1:0] mdu_wdata,
    output logic             mdu_ready,
    output logic             rf_wen,
    output logic [ASIZE-1:0] rf_waddr,
    output logic [DSIZE-1:0] rf_wdata,
    output logic             pipe_stall,
    output logic             err_alu_in_stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [ASIZE-1:0] r_addr [DEPTH];
    logic [DSIZE-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             w_acc, w_empty, w_head_live, w_pop, w_bypass, w_push, w_starve_hit;

    assign mdu_ready    = r_count < CW'(DEPTH);
    assign w_acc        = mdu_valid && mdu_ready;
    assign w_empty      = r_count == '0;
    assign w_head_live  = !w_empty && r_live[r_rptr];
    assign w_pop        = !alu_valid && !w_empty;
    assign w_bypass     = !alu_valid && w_empty && w_acc;
    // an accepted MDU result aimed at the ALU's register is older, so it is handshaken and dropped
    assign w_push       = w_acc && !w_bypass && !(alu_valid && mdu_waddr == alu_waddr);
    assign w_starve_hit = alu_valid && w_head_live && r_starve == SW'(STARVE_LIMIT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_live           <= '0;
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_count          <= '0;
            r_starve         <= '0;
            rf_wen           <= 1'b0;
            rf_waddr         <= '0;
            rf_wdata         <= '0;
            pipe_stall       <= 1'b0;
            err_alu_in_stall <= 1'b0;
        end else begin
            rf_wen <= alu_valid || (w_pop && w_head_live) || w_bypass;
            if (alu_valid) begin
                rf_waddr <= alu_waddr;
                rf_wdata <= alu_wdata;
            end else if (w_pop && w_head_live) begin
                rf_waddr <= r_addr[r_rptr];
                rf_wdata <= r_data[r_rptr];
            end else if (w_bypass) begin
                rf_waddr <= mdu_waddr;
                rf_wdata <= mdu_wdata;
            end
            for (int i = 0; i < DEPTH; i++)
                if (alu_valid && r_addr[i] == alu_waddr) r_live[i] <= 1'b0;
            if (w_push) begin
                r_live[r_wptr] <= 1'b1;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_starve   <= (w_pop || w_empty || w_starve_hit) ? '0 : r_starve + SW'(alu_valid && w_head_live);
            pipe_stall <= w_starve_hit;
            if (pipe_stall && alu_valid) err_alu_in_stall <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (w_push) begin
            r_addr[r_wptr] <= mdu_waddr;
            r_data[r_wptr] <= mdu_wdata;
        end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic checked against a queue-based model
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mdu_valid = 1'b0;
    logic [4:0]  alu_waddr = '0, mdu_waddr = '0;
    logic [15:0] alu_wdata = '0, mdu_wdata = '0;
    logic        mdu_ready, rf_wen, pipe_stall, err_alu_in_stall;
    logic [4:0]  rf_waddr;
    logic [15:0] rf_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
        bit          live;
    } entry_t;

    entry_t      m_q[$];
    int          m_starve = 0;
    bit          m_stall = 0, m_err = 0, m_wen = 0;
    logic [4:0]  m_addr = '0;
    logic [15:0] m_data = '0;

    wb_port_arbiter #(.DSIZE(16), .ASIZE(5), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .mdu_ready(mdu_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .err_alu_in_stall(err_alu_in_stall)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic va, input logic [4:0] aa, input logic [15:0] ad,
                              input logic vm, input logic [4:0] ma, input logic [15:0] md);
        bit acc, pop, bypass, hl, nstall;
        entry_t e;
        if (r) begin
            m_q.delete();
            m_starve = 0; m_stall = 0; m_err = 0; m_wen = 0; m_addr = '0; m_data = '0;
        end else begin
            acc    = vm && (m_q.size() < DEPTH);
            hl     = (m_q.size() > 0) ? m_q[0].live : 1'b0;
            pop    = !va && m_q.size() > 0;
            bypass = !va && m_q.size() == 0 && acc;
            nstall = 0;
            if (m_stall && va) m_err = 1;
            m_wen = va || (pop && hl) || bypass;
            if (va) begin m_addr = aa; m_data = ad; end
            else if (pop && hl) begin m_addr = m_q[0].a; m_data = m_q[0].d; end
            else if (bypass) begin m_addr = ma; m_data = md; end
            if (pop || m_q.size() == 0) m_starve = 0;
            else if (va && hl) begin
                m_starve = m_starve + 1;
                if (m_starve == LIMIT) begin nstall = 1; m_starve = 0; end
            end
            if (va) foreach (m_q[i]) if (m_q[i].a == aa) m_q[i].live = 0;
            if (pop) void'(m_q.pop_front());
            if (acc && !bypass && !(va && ma == aa)) begin
                e.a = ma; e.d = md; e.live = 1;
                m_q.push_back(e);
            end
            m_stall = nstall;
        end
    endtask

    task automatic tick(input logic r, input logic va, input logic [4:0] aa, input logic [15:0] ad,
                        input logic vm, input logic [4:0] ma, input logic [15:0] md);
        rst = r; alu_valid = va; alu_waddr = aa; alu_wdata = ad;
        mdu_valid = vm; mdu_waddr = ma; mdu_wdata = md;
        model_step(r, va, aa, ad, vm, ma, md);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen got=%b want=0", rf_wen); end
        n_cmp++; if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", pipe_stall); end
        n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", mdu_ready); end
        n_cmp++; if (err_alu_in_stall !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_alu_in_stall); end
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            n_cmp++;
            if ({rf_wen, pipe_stall, err_alu_in_stall, rf_waddr, rf_wdata} !== '0) begin
                n_bad++;
                $display("FAIL idle_outputs cycle=%0d got wen=%b stall=%b err=%b addr=%0d data=%h want all 0",
                         k, rf_wen, pipe_stall, err_alu_in_stall, rf_waddr, rf_wdata);
            end
        end
    endtask

    task automatic test_alu_only;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 3, 16'h1234, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 16'h1234}) begin
            n_bad++; $display("FAIL alu_write got=%b/%0d/%h want=1/3/1234", rf_wen, rf_waddr, rf_wdata);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 16'h1234}) begin
            n_bad++; $display("FAIL alu_hold got=%b/%0d/%h want=0/3/1234", rf_wen, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_bypass;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 7, 16'hBEEF);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 16'hBEEF}) begin
            n_bad++; $display("FAIL bypass_write got=%b/%0d/%h want=1/7/beef", rf_wen, rf_waddr, rf_wdata);
        end
        n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL bypass_not_buffered ready got=%b want=1", mdu_ready); end
        tick(0, 1, 2, 16'h2222, 1, 7, 16'hBEEF);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 16'h2222}) begin
            n_bad++; $display("FAIL buffer_alu_first got=%b/%0d/%h want=1/2/2222", rf_wen, rf_waddr, rf_wdata);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 16'hBEEF}) begin
            n_bad++; $display("FAIL buffer_mdu_next got=%b/%0d/%h want=1/7/beef", rf_wen, rf_waddr, rf_wdata);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL buffer_drained wen got=%b want=0", rf_wen); end
    endtask

    task automatic test_full;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 10, 16'h0010, 1, 20, 16'hA001);
        tick(0, 1, 11, 16'h0011, 1, 21, 16'hA002);
        n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b want=0", mdu_ready); end
        tick(0, 1, 12, 16'h0012, 1, 22, 16'hA003);
        n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold_ready got=%b want=0", mdu_ready); end
        tick(0, 0, 0, 0, 1, 22, 16'hA003);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd20, 16'hA001}) begin
            n_bad++; $display("FAIL full_pop1 got=%b/%0d/%h want=1/20/a001", rf_wen, rf_waddr, rf_wdata);
        end
        n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after_pop got=%b want=1", mdu_ready); end
        tick(0, 0, 0, 0, 1, 22, 16'hA003);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd21, 16'hA002}) begin
            n_bad++; $display("FAIL full_pop2 got=%b/%0d/%h want=1/21/a002", rf_wen, rf_waddr, rf_wdata);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd22, 16'hA003}) begin
            n_bad++; $display("FAIL full_pop3 got=%b/%0d/%h want=1/22/a003", rf_wen, rf_waddr, rf_wdata);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if ({rf_wen, pipe_stall} !== 2'b00) begin n_bad++; $display("FAIL full_empty got wen/stall=%b want=00", {rf_wen, pipe_stall}); end
    endtask

    task automatic starve_setup;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 16'h0001, 1, 5, 16'h00AA);
        for (int k = 0; k < LIMIT; k++) begin
            tick(0, 1, (k == LIMIT - 1) ? 5'd6 : 5'(k + 1), 16'(k), 0, 0, 0);
            n_cmp++;
            if (pipe_stall !== (k == LIMIT - 1)) begin
                n_bad++; $display("FAIL starve_stall cycle=%0d got=%b want=%b", k, pipe_stall, k == LIMIT - 1);
            end
        end
    endtask

    task automatic test_starvation;
        starve_setup();
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 16'h00AA}) begin
            n_bad++; $display("FAIL starve_drain got=%b/%0d/%h want=1/5/00aa", rf_wen, rf_waddr, rf_wdata);
        end
        n_cmp++; if (pipe_stall !== 1'b0) begin n_bad++; $display("FAIL starve_stall_end got=%b want=0", pipe_stall); end
        n_cmp++; if (err_alu_in_stall !== 1'b0) begin n_bad++; $display("FAIL starve_err got=%b want=0", err_alu_in_stall); end
    endtask

    task automatic test_kill;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 16'h0001, 1, 9, 16'h0999);
        tick(0, 1, 9, 16'h9999, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 16'h9999}) begin
            n_bad++; $display("FAIL kill_alu got=%b/%0d/%h want=1/9/9999", rf_wen, rf_waddr, rf_wdata);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL kill_dead_pop wen got=%b want=0", rf_wen); end
        n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL kill_slot_freed ready got=%b want=1", mdu_ready); end
        tick(0, 1, 4, 16'h4444, 1, 4, 16'h0444);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 16'h4444}) begin
            n_bad++; $display("FAIL drop_alu got=%b/%0d/%h want=1/4/4444", rf_wen, rf_waddr, rf_wdata);
        end
        n_cmp++; if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL drop_not_pushed ready got=%b want=1", mdu_ready); end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL drop_no_write wen got=%b want=0", rf_wen); end
    endtask

    task automatic test_err;
        starve_setup();
        tick(0, 1, 8, 16'h8888, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 16'h8888}) begin
            n_bad++; $display("FAIL err_alu_wins got=%b/%0d/%h want=1/8/8888", rf_wen, rf_waddr, rf_wdata);
        end
        n_cmp++; if (err_alu_in_stall !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b want=1", err_alu_in_stall); end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 16'h00AA}) begin
            n_bad++; $display("FAIL err_late_drain got=%b/%0d/%h want=1/5/00aa", rf_wen, rf_waddr, rf_wdata);
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (err_alu_in_stall !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=1", err_alu_in_stall); end
        tick(1, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (err_alu_in_stall !== 1'b0) begin n_bad++; $display("FAIL err_cleared got=%b want=0", err_alu_in_stall); end
    endtask

    task automatic test_random;
        logic r, va, vm;
        logic [4:0] aa, ma;
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            n_cmp++;
            if (mdu_ready !== (m_q.size() < DEPTH)) begin
                n_bad++; $display("FAIL rnd_ready cycle=%0d got=%b want=%b", k, mdu_ready, m_q.size() < DEPTH);
            end
            r  = $urandom_range(0, 499) == 0;
            va = pipe_stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 99) < 55);
            vm = $urandom_range(0, 99) < 45;
            aa = 5'($urandom_range(0, 7));
            ma = 5'($urandom_range(0, 7));
            tick(r, va, aa, 16'($urandom), vm, ma, 16'($urandom));
            n_cmp++;
            if ({rf_wen, pipe_stall, err_alu_in_stall} !== {m_wen, m_stall, m_err}) begin
                n_bad++;
                $display("FAIL rnd_ctrl cycle=%0d got wen/stall/err=%b%b%b want=%b%b%b",
                         k, rf_wen, pipe_stall, err_alu_in_stall, m_wen, m_stall, m_err);
            end
            if (m_wen) begin
                n_cmp++;
                if ({rf_waddr, rf_wdata} !== {m_addr, m_data}) begin
                    n_bad++; $display("FAIL rnd_data cycle=%0d got=%0d/%h want=%0d/%h", k, rf_waddr, rf_wdata, m_addr, m_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_bypass();
        test_full();
        test_starvation();
        test_kill();
        test_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
